// File: rtl/pf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pf_pkg
// Brief    : Shared types and defaults for the prefetch issue controller.
// Revision : 1.0
// ============================================================================
package pf_pkg;

  localparam int PF_N      = 8;
  localparam int PF_TAG_W  = 4;
  localparam int PF_ADDR_W = 64;

  typedef enum logic [2:0] {
    FREE = 3'd0,
    PEND = 3'd1,
    SEL  = 3'd2,
    WAIT = 3'd3,
    SQ   = 3'd4
  } pf_state_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } pf_fsm_e;

  // Storage widths are the package maxima; the controller's ADDR_W/TAG_W must not exceed them.
  typedef struct packed {
    pf_state_e              state;
    logic [PF_ADDR_W-1:0]   addr;
    logic [PF_TAG_W-1:0]    tag;
  } pf_entry_t;

endpackage
`default_nettype wire

// File: rtl/rpsN.sv
`default_nettype none
// ============================================================================
// Module   : rpsN
// Brief    : Round-robin priority selector; first request at or after ptr_i wins.
// Revision : 1.0
// ============================================================================
module rpsN #(
  parameter int N = 8
) (
  input  logic                 en_i,
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int c_IDX_W = $clog2(N);

  logic [c_IDX_W-1:0] w_idx;
  logic               w_found;

  // N is a power of two, so the index sum wraps on its own.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = ptr_i + c_IDX_W'(i);
      if (en_i && !w_found && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        gnt_idx_o    = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pf_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pf_issue_ctrl
// Brief    : Next-line prefetch issue controller: queue, memory handshake, fill.
// Revision : 1.0
// ============================================================================
module pf_issue_ctrl
  import pf_pkg::*;
#(
  parameter int N      = PF_N,
  parameter int ADDR_W = 64,
  parameter int TAG_W  = PF_TAG_W,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  output logic              alloc_ready_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic [TAG_W-1:0]  mem_req_tag_i,
  input  logic [TAG_W-1:0]  mem_cpl_tag_i,
  input  logic [DATA_W-1:0] mem_cpl_data_i,
  output logic              fill_valid_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [DATA_W-1:0] fill_data_o
);

  localparam int c_IDX_W = $clog2(N);

  pf_entry_t          r_ent     [N];
  pf_entry_t          w_ent_nxt [N];
  pf_fsm_e            r_fsm, w_fsm_nxt;
  logic [c_IDX_W-1:0] r_ptr, r_gnt_idx, w_free_idx, w_gnt_idx;
  logic [N-1:0]       w_pend_vec, w_gnt;
  logic               w_free_any, w_dup, w_alloc, w_accept, w_rps_en;
  logic               w_fill_hit;
  logic [ADDR_W-1:0]  w_fill_addr;
  logic               r_req_valid, r_fill_valid;
  logic [ADDR_W-1:0]  r_req_addr, r_fill_addr;
  logic [DATA_W-1:0]  r_fill_data;

  // Descending scan so the lowest-index FREE entry is the one left in w_free_idx.
  always_comb begin
    w_pend_vec = '0;
    w_free_idx = '0;
    w_free_any = 1'b0;
    w_dup      = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      w_pend_vec[i] = (r_ent[i].state == PEND);
      if (r_ent[i].state == FREE) begin
        w_free_idx = c_IDX_W'(i);
        w_free_any = 1'b1;
      end
      if ((r_ent[i].state == PEND || r_ent[i].state == SEL || r_ent[i].state == WAIT) &&
          r_ent[i].addr == PF_ADDR_W'(alloc_addr_i)) begin
        w_dup = 1'b1;
      end
    end
  end

  assign alloc_ready_o = w_free_any;
  assign w_rps_en      = (r_fsm == IDLE) && !flush_i;
  assign w_accept      = (r_fsm == REQ) && mem_req_ready_i;
  assign w_alloc       = alloc_en_i && !flush_i && w_free_any && !w_dup;

  rpsN #(.N(N)) u_rps (
    .en_i      (w_rps_en),
    .req_i     (w_pend_vec),
    .ptr_i     (r_ptr),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // Completion, then accept, then flush-or-(alloc, grant) layered on the same next-state copy.
  always_comb begin
    w_ent_nxt   = r_ent;
    w_fill_hit  = 1'b0;
    w_fill_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (mem_cpl_tag_i != '0 && (r_ent[i].state == WAIT || r_ent[i].state == SQ) &&
          r_ent[i].tag == PF_TAG_W'(mem_cpl_tag_i)) begin
        if (r_ent[i].state == WAIT) begin
          w_fill_hit  = 1'b1;
          w_fill_addr = r_ent[i].addr[ADDR_W-1:0];
        end
        w_ent_nxt[i].state = FREE;
      end
    end
    if (w_accept) begin
      if (r_ent[r_gnt_idx].state == SEL) begin
        w_ent_nxt[r_gnt_idx].state = WAIT;
      end
      w_ent_nxt[r_gnt_idx].tag = PF_TAG_W'(mem_req_tag_i);
    end
    if (flush_i) begin
      for (int i = 0; i < N; i++) begin
        if (w_ent_nxt[i].state == PEND) begin
          w_ent_nxt[i].state = FREE;
        end else if (w_ent_nxt[i].state == SEL || w_ent_nxt[i].state == WAIT) begin
          w_ent_nxt[i].state = SQ;
        end
      end
    end else begin
      if (w_alloc) begin
        w_ent_nxt[w_free_idx].state = PEND;
        w_ent_nxt[w_free_idx].addr  = PF_ADDR_W'(alloc_addr_i);
        w_ent_nxt[w_free_idx].tag   = '0;
      end
      // Tag cleared at grant so a squash before accept cannot match a stale tag.
      if (|w_gnt) begin
        w_ent_nxt[w_gnt_idx].state = SEL;
        w_ent_nxt[w_gnt_idx].tag   = '0;
      end
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (|w_gnt) w_fsm_nxt = REQ;
      REQ:     if (mem_req_ready_i) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_ent[i] <= '{state: FREE, addr: '0, tag: '0};
      end
      r_ptr        <= '0;
      r_gnt_idx    <= '0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
    end else begin
      r_ent        <= w_ent_nxt;
      r_fill_valid <= w_fill_hit;
      if (w_fill_hit) begin
        r_fill_addr <= w_fill_addr;
        r_fill_data <= mem_cpl_data_i;
      end
      if (|w_gnt) begin
        r_gnt_idx   <= w_gnt_idx;
        r_req_valid <= 1'b1;
        r_req_addr  <= r_ent[w_gnt_idx].addr[ADDR_W-1:0];
      end
      if (w_accept) begin
        r_req_valid <= 1'b0;
        r_ptr       <= r_gnt_idx + c_IDX_W'(1);
      end
    end
  end

  assign mem_req_valid_o = r_req_valid;
  assign mem_req_addr_o  = r_req_addr;
  assign fill_valid_o    = r_fill_valid;
  assign fill_addr_o     = r_fill_addr;
  assign fill_data_o     = r_fill_data;

endmodule
`default_nettype wire

// File: doc/pf_issue_ctrl.md
# pf_issue_ctrl

Prefetch issue controller for the instruction-fetch prefetch path. Holds up to N outstanding next-line prefetch addresses and picks one per issue slot through the round-robin priority selector `rpsN`. Drives the memory request handshake, tracks outstanding memory tags, and returns completed blocks to the I-cache fill port. It sits between the next-line address generator (upstream) and the memory interface and I-cache (downstream).

## Interface
- `N`, default 8: prefetch entries; power of two, matches `rpsN` width.
- `ADDR_W`, default 64: block address width.
- `TAG_W`, default 4: memory transaction tag width; tag 0 means "no tag".
- `DATA_W`, default 64: fill data width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alloc_en_i`  in  1  request to enqueue a prefetch address.
- `alloc_addr_i`  in  ADDR_W  block-aligned prefetch address.
- `alloc_ready_o`  out  1  at least one entry is FREE (combinational from entry state).
- `flush_i`  in  1  squash all prefetches (mispredict or redirect).
- `mem_req_valid_o`  out  1  memory request valid (registered).
- `mem_req_addr_o`  out  ADDR_W  request address (registered).
- `mem_req_ready_i`  in  1  memory accepts the request this cycle.
- `mem_req_tag_i`  in  TAG_W  tag assigned by memory; valid only in the accept cycle; nonzero.
- `mem_cpl_tag_i`  in  TAG_W  completion tag; 0 = no completion this cycle.
- `mem_cpl_data_i`  in  DATA_W  completion data, valid with a nonzero `mem_cpl_tag_i`.
- `fill_valid_o`  out  1  one-cycle pulse: block delivered to the I-cache.
- `fill_addr_o`  out  ADDR_W  address of the delivered block.
- `fill_data_o`  out  DATA_W  data of the delivered block.

## Operation
- Each entry has a state, an address and a tag. Entry states:
  - FREE: unused.
  - PEND: allocated, not yet issued.
  - SEL: granted and presented on the memory port.
  - WAIT: accepted by memory, waiting for its completion.
  - SQ: squashed while SEL or WAIT; its completion is discarded.
- **Allocation**
  - Fires when `alloc_en_i` is high, `flush_i` is low and a FREE entry exists.
  - Takes the lowest-index FREE entry, which goes to PEND.
  - The request is dropped silently if the address equals the address of any PEND, SEL or WAIT entry (dedup). SQ entries are not compared.
  - The request is also dropped when no entry is FREE.
- **Issue FSM**, states IDLE and REQ:
  - IDLE: `rpsN` is enabled with `req_i` set to the PEND vector and `ptr_i` set to the round-robin pointer. A nonzero grant moves the granted entry to SEL, latches its address into `mem_req_addr_o`, sets `mem_req_valid_o`, and moves the FSM to REQ.
  - REQ: valid and address are held stable until `mem_req_ready_i` is high. In the accept cycle:
    - the entry goes to WAIT (or stays SQ if it was squashed) and records `mem_req_tag_i`;
    - the pointer becomes (granted index + 1) mod N;
    - `mem_req_valid_o` clears and the FSM returns to IDLE.
- **Completion**
  - A nonzero `mem_cpl_tag_i` matching a WAIT entry frees that entry and registers `fill_valid_o`=1 with that entry's address and the completion data.
  - A tag matching an SQ entry frees the entry with no fill.
  - A tag matching no entry is ignored.
  - Memory guarantees that tags are unique among outstanding transactions.
- **Flush**
  - PEND entries become FREE; SEL and WAIT entries become SQ.
  - An in-progress REQ is never retracted: the handshake completes and the entry stays SQ.
  - `rpsN` is disabled in a flush cycle. The pointer is unchanged.

## Timing
- Reset values:
  - every entry FREE; pointer 0; FSM IDLE;
  - `mem_req_valid_o`=0, `mem_req_addr_o`=0;
  - `fill_valid_o`=0, `fill_addr_o`=0, `fill_data_o`=0;
  - `alloc_ready_o`=1.
- Alloc in cycle t: the entry is PEND at t+1, and `mem_req_valid_o` is high at t+2 if the FSM is IDLE.
- Accept in cycle a: the FSM is IDLE at a+1 and the next valid is high at a+2 at the earliest. Peak rate is one issue every 2 cycles.
- Completion in cycle c: `fill_valid_o` is high for exactly cycle c+1, and the entry is FREE at c+1. The entry is allocatable by an alloc in c+1, which is visible at c+2.
- A completion and an allocation in the same cycle: the freed entry is not available to that allocation.
- Flush together with alloc: flush wins and the alloc is dropped.
- Flush together with completion: the completion is processed (fill emitted if the entry was WAIT before the flush), then the flush applies to the remaining entries.
- Flush together with accept: the entry records its tag and ends in SQ.
- Asynchronous reset mid-transaction clears everything immediately. Outstanding memory completions arriving after reset match no entry and are ignored.

## Structure
- Shared package `pf_pkg` contains:
  - the entry-state enum `pf_state_e` (FREE, PEND, SEL, WAIT, SQ);
  - the FSM enum `pf_fsm_e` (IDLE, REQ);
  - the entry struct `pf_entry_t` (state, addr, tag);
  - default constants `PF_N`, `PF_TAG_W`.
- There is one sub-module: `rpsN`, instantiated once as the grant selector. Everything else is local to `pf_issue_ctrl`.

## Test plan
- Reset, then allocate 0x1000, with ready held high and tag 3: `mem_req_valid_o`=1 with address 0x1000 two cycles after the alloc. Completion tag 3 with data 0xDEAD gives one `fill_valid_o` pulse with 0x1000/0xDEAD.
- Fill all 8 entries (0x0..0x380 step 0x80), then a 9th alloc: `alloc_ready_o`=0 and the 9th is dropped. Grants are issued in index order 0..7 while the pointer advances.
- Round-robin: issue entry 2 while entries 0 and 5 are PEND with pointer 3: entry 5 is granted before entry 0.
- Dedup: allocate 0x2000 twice, in different cycles, while the first is still PEND: only one entry is used and only one request is issued.
- Flush while REQ is stalled (ready low for 5 cycles): valid and address are held, the accept happens, and the later completion produces no fill. The entry is FREE after the completion, and the PEND entries are FREE immediately.
- Assert `rst_n` low mid-REQ: all outputs return to reset values asynchronously. A later completion tag matches no entry and produces no fill.
